// File: rtl/ctrl_reg_pkg.sv
// Shared definitions for the control-register sync/arm block.
// Field positions inside the 32-bit software control word and the
// sequencer state encoding.
package ctrl_reg_pkg;

  localparam int unsigned ARM_BIT        = 0;
  localparam int unsigned SW_SYNC_BIT    = 1;
  localparam int unsigned CNT_RST_BIT    = 2;
  localparam int unsigned CLR_STATUS_BIT = 3;

  localparam int unsigned OFFSET_LSB = 16;
  localparam int unsigned OFFSET_W   = 16;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    DELAY
  } seq_state_e;

endpackage

// File: rtl/ctrl_reg_sync_arm_if.sv
// Bus bundle between the control register side and ctrl_reg_sync_arm.
//   reg_in, ext_sync_in           : driven by the master (register / sync source)
//   sync_out, armed, cnt_rst_pulse,
//   sync_count, reg_filt          : driven by the slave (ctrl_reg_sync_arm)
interface ctrl_reg_sync_arm_if #(
  parameter int unsigned CNT_W = 8
);
  logic [31:0]      reg_in;
  logic             ext_sync_in;
  logic             sync_out;
  logic             armed;
  logic             cnt_rst_pulse;
  logic [CNT_W-1:0] sync_count;
  logic [31:0]      reg_filt;

  modport master (
    output reg_in,
    output ext_sync_in,
    input  sync_out,
    input  armed,
    input  cnt_rst_pulse,
    input  sync_count,
    input  reg_filt
  );

  modport slave (
    input  reg_in,
    input  ext_sync_in,
    output sync_out,
    output armed,
    output cnt_rst_pulse,
    output sync_count,
    output reg_filt
  );
endinterface

// File: rtl/reg_stable_filter.sv
// Anti-tearing filter for a software register crossing into fabric logic.
// The input is registered, and the filtered value only follows once the
// registered copy has stayed unchanged for StableCycles further cycles.
//   clk_i, rst_ni : clock, async active-low reset
//   data_i        : raw register value
//   data_filt_o   : last accepted value
//   valid_o       : set by the first acceptance after reset (baseline taken)
module reg_stable_filter #(
  parameter int unsigned STABLE_CYCLES = 2,
  parameter int unsigned WIDTH         = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_filt_o,
  output logic             valid_o
);

  localparam int unsigned CntW = 4;
  localparam logic [CntW-1:0] Stable = CntW'(STABLE_CYCLES);

  logic [WIDTH-1:0] reg_q, reg_d;
  logic [WIDTH-1:0] filt_q, filt_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             load;

  always_comb begin
    reg_d = data_i;
    // cnt_q = number of extra cycles reg_q has held its value; saturates.
    if (data_i != reg_q) begin
      cnt_d = '0;
    end else if (cnt_q != Stable) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end
    load    = (cnt_q == Stable);
    filt_d  = load ? reg_q : filt_q;
    valid_d = valid_q | load;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      reg_q   <= '0;
      filt_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      reg_q   <= reg_d;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign data_filt_o = filt_q;
  assign valid_o     = valid_q;

endmodule

// File: rtl/ctrl_reg_sync_arm.sv
// Turns the software control word into clean pulses and an arm/sync
// sequencer that re-times an external sync by a programmed offset.
//   user_clk, user_rst_n : clock, async active-low reset
//   bus.reg_in           : control word (arm, sw_sync, cnt_rst, clr_status, offset)
//   bus.ext_sync_in      : external sync pulse
//   bus.sync_out         : re-timed sync pulse
//   bus.armed            : sequencer waiting for or delaying a sync
//   bus.cnt_rst_pulse    : pulse on cnt_rst rising edge
//   bus.sync_count       : emitted sync_out pulses, wrapping
//   bus.reg_filt         : accepted control word
module ctrl_reg_sync_arm
  import ctrl_reg_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 2,
  parameter int unsigned CNT_W         = 8
) (
  input  logic                user_clk,
  input  logic                user_rst_n,
  ctrl_reg_sync_arm_if.slave  bus
);

  logic [31:0]         reg_filt;
  logic                filt_valid;

  logic [3:0]          prev_q, prev_d;
  logic                prev_valid_q, prev_valid_d;
  logic [3:0]          edge_q, edge_d;
  seq_state_e          state_q, state_d;
  logic [OFFSET_W-1:0] dcnt_q, dcnt_d;
  logic                sync_out_q, sync_out_d;
  logic [CNT_W-1:0]    sync_count_q, sync_count_d;
  logic [OFFSET_W-1:0] offset;

  reg_stable_filter #(
    .STABLE_CYCLES (STABLE_CYCLES),
    .WIDTH         (32)
  ) u_filter (
    .clk_i       (user_clk),
    .rst_ni      (user_rst_n),
    .data_i      (bus.reg_in),
    .data_filt_o (reg_filt),
    .valid_o     (filt_valid)
  );

  assign offset = reg_filt[OFFSET_LSB +: OFFSET_W];

  always_comb begin
    prev_d       = reg_filt[3:0];
    // prev_q only holds an accepted value once the baseline was taken a cycle earlier.
    prev_valid_d = filt_valid;
    edge_d       = reg_filt[3:0] & ~prev_q & {4{prev_valid_q}};

    state_d    = state_q;
    dcnt_d     = dcnt_q;
    sync_out_d = 1'b0;
    if (edge_q[SW_SYNC_BIT]) begin
      // Software sync overrides everything and cancels a pending delay.
      sync_out_d = 1'b1;
      state_d    = IDLE;
      dcnt_d     = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (edge_q[ARM_BIT]) state_d = ARMED;
        end
        ARMED: begin
          if (bus.ext_sync_in) begin
            if (offset == '0) begin
              sync_out_d = 1'b1;
              state_d    = IDLE;
            end else begin
              dcnt_d  = offset;
              state_d = DELAY;
            end
          end
        end
        DELAY: begin
          dcnt_d = dcnt_q - 1'b1;
          if (dcnt_q == OFFSET_W'(1)) begin
            sync_out_d = 1'b1;
            state_d    = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Clear wins over a coincident sync_out.
    if (edge_q[CLR_STATUS_BIT]) begin
      sync_count_d = '0;
    end else if (sync_out_q) begin
      sync_count_d = sync_count_q + 1'b1;
    end else begin
      sync_count_d = sync_count_q;
    end
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      edge_q       <= '0;
      state_q      <= IDLE;
      dcnt_q       <= '0;
      sync_out_q   <= 1'b0;
      sync_count_q <= '0;
    end else begin
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      edge_q       <= edge_d;
      state_q      <= state_d;
      dcnt_q       <= dcnt_d;
      sync_out_q   <= sync_out_d;
      sync_count_q <= sync_count_d;
    end
  end

  assign bus.sync_out      = sync_out_q;
  assign bus.armed         = (state_q != IDLE);
  assign bus.cnt_rst_pulse = edge_q[CNT_RST_BIT];
  assign bus.sync_count    = sync_count_q;
  assign bus.reg_filt      = reg_filt;

endmodule

// File: tb/tb_ctrl_reg_sync_arm.sv
module tb_ctrl_reg_sync_arm;

  localparam int unsigned S     = 2;
  localparam int          Depth = 8192;

  logic clk;
  logic rst_n;

  ctrl_reg_sync_arm_if #(.CNT_W(8)) bus ();

  ctrl_reg_sync_arm #(
    .STABLE_CYCLES (S),
    .CNT_W         (8)
  ) dut (
    .user_clk   (clk),
    .user_rst_n (rst_n),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: history of sampled words since reset, accepted words,
  // and an abstract sequencer mode with an absolute sync deadline.
  logic [31:0] rq   [Depth];
  logic [31:0] filt [Depth];
  bit          valid[Depth];
  int          k;
  int          m_mode;      // 0 idle, 1 waiting for ext sync, 2 waiting for deadline
  int          m_deadline;
  bit          m_sync;
  logic [7:0]  m_count;
  logic [3:0]  e_cur;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (k=%0d, t=%0t)", tag, obs, exp, k, $time);
    end
  endtask

  task automatic model_reset();
    k       = 0;
    rq[0]   = '0;
    filt[0] = '0;
    valid[0] = 1'b0;
    m_mode  = 0;
    m_deadline = 0;
    m_sync  = 1'b0;
    m_count = '0;
    e_cur   = '0;
  endtask

  task automatic step(input logic [31:0] rin, input logic ext);
    bit         load;
    logic [3:0] e_new;
    logic [15:0] off;
    bus.reg_in      = rin;
    bus.ext_sync_in = ext;
    @(posedge clk);
    #1;
    k++;
    if (k >= Depth) begin
      $display("FAIL model_depth: got %0d expected below %0d", k, Depth);
      $fatal(1, "model history exhausted");
    end
    rq[k] = rin;
    // Accept once S+1 consecutive samples (reset value included) agree.
    load = 1'b0;
    if (k >= int'(S) + 1) begin
      load = 1'b1;
      for (int j = k - 1 - int'(S); j < k; j++) if (rq[j] != rq[k-1]) load = 1'b0;
    end
    filt[k]  = load ? rq[k-1] : filt[k-1];
    valid[k] = valid[k-1] | load;
    e_new = 4'b0;
    if (k >= 2) begin
      if (valid[k-2]) e_new = filt[k-1][3:0] & ~filt[k-2][3:0];
    end
    m_count = e_cur[3] ? 8'd0 : m_count + 8'(m_sync);
    m_sync = 1'b0;
    if (e_cur[1]) begin
      m_sync = 1'b1;
      m_mode = 0;
    end else if (m_mode == 0) begin
      if (e_cur[0]) m_mode = 1;
    end else if (m_mode == 1) begin
      if (ext) begin
        off = filt[k-1][31:16];
        if (off == 16'd0) begin
          m_sync = 1'b1;
          m_mode = 0;
        end else begin
          m_deadline = k + int'(off);
          m_mode = 2;
        end
      end
    end else if (k == m_deadline) begin
      m_sync = 1'b1;
      m_mode = 0;
    end
    e_cur = e_new;
    check_eq("sync_out", {31'b0, bus.sync_out}, {31'b0, m_sync});
    check_eq("armed", {31'b0, bus.armed}, {31'b0, (m_mode != 0)});
    check_eq("cnt_rst_pulse", {31'b0, bus.cnt_rst_pulse}, {31'b0, e_cur[2]});
    check_eq("sync_count", {24'b0, bus.sync_count}, {24'b0, m_count});
    check_eq("reg_filt", bus.reg_filt, filt[k]);
  endtask

  task automatic hold(input logic [31:0] rin, input int n);
    for (int i = 0; i < n; i++) step(rin, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_sync_out"}, {31'b0, bus.sync_out}, 32'h0);
    check_eq({tag, "_armed"}, {31'b0, bus.armed}, 32'h0);
    check_eq({tag, "_cnt_rst"}, {31'b0, bus.cnt_rst_pulse}, 32'h0);
    check_eq({tag, "_count"}, {24'b0, bus.sync_count}, 32'h0);
    check_eq({tag, "_filt"}, bus.reg_filt, 32'h0);
  endtask

  initial begin
    int n_sync;
    int k_ext;
    int k_seen;
    int n_pulse;

    rst_n           = 1'b0;
    bus.reg_in      = 32'h0000_0001;
    bus.ext_sync_in = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Baseline acceptance: reg_filt follows, no arm edge.
    for (int i = 0; i < 6; i++) begin
      step(32'h0000_0001, 1'b0);
      if (k == int'(S) + 2) check_eq("baseline_filt", bus.reg_filt, 32'h1);
    end
    check_eq("baseline_armed", {31'b0, bus.armed}, 32'h0);
    hold(32'h0, 5);

    // Arm with offset 5.
    hold(32'h0005_0001, 8);
    check_eq("arm_before_ext", {31'b0, bus.armed}, 32'h1);
    step(32'h0005_0001, 1'b1);
    k_ext = k; k_seen = -1; n_sync = 0;
    for (int i = 0; i < 10; i++) begin
      step(32'h0005_0001, 1'b0);
      if (bus.sync_out) begin n_sync++; k_seen = k; end
    end
    check_eq("delay5_nsync", n_sync, 1);
    check_eq("delay5_latency", k_seen - k_ext, 5);
    check_eq("delay5_count", {24'b0, bus.sync_count}, 32'h1);

    // Tearing: alternating word never accepted; one pulse after hold.
    n_pulse = 0;
    for (int i = 0; i < 20; i++) begin
      step((i % 2 == 1) ? 32'h4 : 32'h0, 1'b0);
      n_pulse += int'(bus.cnt_rst_pulse);
    end
    check_eq("tear_no_pulse", n_pulse, 0);
    for (int i = 0; i < 8; i++) begin
      step(32'h4, 1'b0);
      n_pulse += int'(bus.cnt_rst_pulse);
    end
    check_eq("tear_one_pulse", n_pulse, 1);

    // ext while idle ignored; then retrigger rejection with offset 3.
    n_sync = 0;
    step(32'h4, 1'b1);
    for (int i = 0; i < 4; i++) begin step(32'h4, 1'b0); n_sync += int'(bus.sync_out); end
    check_eq("idle_ext_nsync", n_sync, 0);
    hold(32'h0003_0000, 5);
    hold(32'h0003_0001, 6);
    step(32'h0003_0001, 1'b1);
    k_ext = k; k_seen = -1;
    step(32'h0003_0001, 1'b1);
    n_sync = int'(bus.sync_out);
    for (int i = 0; i < 8; i++) begin
      step(32'h0003_0001, 1'b0);
      if (bus.sync_out) begin n_sync++; k_seen = k; end
    end
    check_eq("retrig_nsync", n_sync, 1);
    check_eq("retrig_latency", k_seen - k_ext, 3);

    // sw_sync cancels a long delay.
    hold(32'h0100_0000, 5);
    hold(32'h0100_0001, 6);
    step(32'h0100_0001, 1'b1);
    hold(32'h0100_0001, 3);
    n_sync = 0;
    for (int i = 0; i < 300; i++) begin
      step(32'h0100_0003, 1'b0);
      n_sync += int'(bus.sync_out);
    end
    check_eq("swsync_nsync", n_sync, 1);
    check_eq("swsync_idle", {31'b0, bus.armed}, 32'h0);

    // Count to 7, then clr_status edge coincident with sync_out.
    hold(32'h0, 5);
    hold(32'h8, 5);
    hold(32'h0, 5);
    for (int i = 0; i < 7; i++) begin
      hold(32'h2, 5);
      hold(32'h0, 5);
    end
    check_eq("count_seven", {24'b0, bus.sync_count}, 32'h7);
    hold(32'h1, 6);
    hold(32'h9, int'(S) + 2);
    step(32'h9, 1'b1);
    check_eq("collide_sync", {31'b0, bus.sync_out}, 32'h1);
    step(32'h9, 1'b0);
    check_eq("collide_count", {24'b0, bus.sync_count}, 32'h0);
    hold(32'h0, 6);

    // Randomized traffic.
    for (int i = 0; i < 200; i++) begin
      logic [31:0] val;
      int          len;
      val = {16'($urandom_range(0, 6)), 12'h0, 4'($urandom)};
      len = $urandom_range(1, 6);
      for (int j = 0; j < len; j++) step(val, ($urandom_range(0, 7) == 0));
    end

    // Reset in the middle of a delay.
    hold(32'h0, 6);
    hold(32'h0010_0001, 6);
    step(32'h0010_0001, 1'b1);
    hold(32'h0010_0001, 4);
    check_eq("mid_delay_armed", {31'b0, bus.armed}, 32'h1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    n_sync = 0;
    for (int i = 0; i < 40; i++) begin
      step(32'h0010_0001, 1'b0);
      n_sync += int'(bus.sync_out);
    end
    check_eq("post_reset_nsync", n_sync, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
